// File: rtl/credit_buffer_mc.sv
// credit_buffer_mc: multi-channel credit buffer. Each channel owns a private
// DEPTH-entry slice of one shared memory, advertises its free-entry count and
// is drained by a round-robin arbiter into a registered output stage.
//
// Output handshake: te_valid/te_chan/te_data_out are held stable while
// te_valid && !te_ready; a word transfers on any edge where both are high,
// and a new word may load on that same edge.
module credit_buffer_mc #(
  parameter int NCH   = 4,
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(NCH),
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [CW-1:0]         in_chan,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [NCH-1:0]        flush,
  output logic [NCH*(AW+1)-1:0] re_credit,
  output logic [NCH-1:0]        re_credit_ret,
  output logic [NCH-1:0]        overflow,
  output logic                  te_valid,
  input  logic                  te_ready,
  output logic [CW-1:0]         te_chan,
  output logic [WIDTH-1:0]      te_data_out
);

  localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [CW:0] NCH_X   = (CW+1)'(NCH);

  logic [WIDTH-1:0] mem [NCH*DEPTH];
  logic [AW:0]      wr_ptr [NCH];
  logic [AW:0]      rd_ptr [NCH];
  logic [AW:0]      count  [NCH];
  logic [NCH-1:0]   elig;
  logic [CW-1:0]    last_grant;
  logic [CW-1:0]    sel;
  logic [CW-1:0]    cand;
  logic             found;
  logic             load;
  logic             pop;
  logic             chan_ok;
  logic             wr_ok;
  logic             ovf_hit;
  logic [WIDTH-1:0] rd_data;

  // Occupancy, credit and eligibility per channel, all from registered pointers
  always_comb begin
    re_credit = '0;
    elig      = '0;
    for (int c = 0; c < NCH; c++) begin
      count[c] = wr_ptr[c] - rd_ptr[c];
      re_credit[c*(AW+1) +: AW+1] = DEPTH_P - count[c];
      elig[c] = (count[c] != '0) && !flush[c];
    end
  end

  // Write acceptance; a flushed target swallows the write without flagging
  always_comb begin
    chan_ok = {1'b0, in_chan} < NCH_X;
    wr_ok   = in_valid && chan_ok && !flush[in_chan] && (count[in_chan] != DEPTH_P);
    ovf_hit = in_valid && chan_ok && !flush[in_chan] && (count[in_chan] == DEPTH_P);
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    sel   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CW'((int'(last_grant) + k) % NCH);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    load    = !te_valid || te_ready;
    pop     = load && found;
    rd_data = mem[{sel, rd_ptr[sel][AW-1:0]}];
  end

  // Shared storage; contents are not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[{in_chan, wr_ptr[in_chan][AW-1:0]}] <= in_data;
    end
  end

  // Pointer and sticky overflow bookkeeping; flush empties a channel in one edge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
      end
      overflow <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (flush[c]) begin
          rd_ptr[c]   <= wr_ptr[c];
          overflow[c] <= 1'b0;
        end
      end
      if (wr_ok) wr_ptr[in_chan] <= wr_ptr[in_chan] + PTR_ONE;
      if (pop) rd_ptr[sel] <= rd_ptr[sel] + PTR_ONE;
      if (ovf_hit) overflow[in_chan] <= 1'b1;
    end
  end

  // Registered output stage, arbiter history and credit-return pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      te_valid      <= 1'b0;
      te_chan       <= '0;
      te_data_out   <= '0;
      last_grant    <= CW'(NCH - 1);
      re_credit_ret <= '0;
    end else begin
      re_credit_ret <= '0;
      if (load) begin
        if (found) begin
          te_valid           <= 1'b1;
          te_chan            <= sel;
          te_data_out        <= rd_data;
          last_grant         <= sel;
          re_credit_ret[sel] <= 1'b1;
        end else begin
          te_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_credit_buffer_mc.sv
// tb_credit_buffer_mc: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the credit buffer.
module tb_credit_buffer_mc;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;
  localparam int WIDTH = 32;
  localparam int CW    = 2;
  localparam int AW    = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic [CW-1:0]         in_chan;
  logic [WIDTH-1:0]      in_data;
  logic [NCH-1:0]        flush;
  logic [NCH*(AW+1)-1:0] re_credit;
  logic [NCH-1:0]        re_credit_ret;
  logic [NCH-1:0]        overflow;
  logic                  te_valid;
  logic                  te_ready;
  logic [CW-1:0]         te_chan;
  logic [WIDTH-1:0]      te_data_out;

  // clock / reset
  always #5 clk = ~clk;

  credit_buffer_mc #(
    .NCH(NCH), .DEPTH(DEPTH), .WIDTH(WIDTH), .CW(CW), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_chan(in_chan),
    .in_data(in_data), .flush(flush), .re_credit(re_credit),
    .re_credit_ret(re_credit_ret), .overflow(overflow), .te_valid(te_valid),
    .te_ready(te_ready), .te_chan(te_chan), .te_data_out(te_data_out)
  );

  // reference model: one FIFO queue per channel plus the output stage
  logic [WIDTH-1:0]    mq [NCH][$];
  logic                m_valid;
  logic [CW-1:0]       m_chan;
  logic [WIDTH-1:0]    m_data;
  logic [NCH-1:0]      m_ovf;
  logic [NCH-1:0]      m_ret;
  int                  m_last;
  logic [CW+WIDTH-1:0] exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [AW:0] credit_of(input int c);
    return re_credit[c*(AW+1) +: AW+1];
  endfunction

  task automatic check_outputs();
    check("te_valid", te_valid, m_valid);
    check("te_chan", te_chan, m_chan);
    check("te_data", te_data_out, m_data);
    for (int c = 0; c < NCH; c++)
      check($sformatf("re_credit%0d", c), credit_of(c), DEPTH - mq[c].size());
    check("re_credit_ret", re_credit_ret, m_ret);
    check("overflow", overflow, m_ovf);
  endtask

  // driver: apply one cycle of inputs, advance the model, then compare
  task automatic step(input logic v, input int ch, input logic [WIDTH-1:0] d,
                      input logic [NCH-1:0] fl, input logic rdy, input logic rst = 1'b0);
    int sz [NCH];
    logic load;
    bit found;
    bit push_w;
    int sel;
    logic [CW+WIDTH-1:0] exp_w;
    in_valid = v;
    in_chan  = CW'(ch);
    in_data  = d;
    flush    = fl;
    te_ready = rdy;
    reset    = rst;
    if (!rst && te_valid && te_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("deliver", {te_chan, te_data_out}, exp_w);
      end
    end
    if (rst) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_valid = 1'b0;
      m_chan  = '0;
      m_data  = '0;
      m_ovf   = '0;
      m_ret   = '0;
      m_last  = NCH - 1;
      exp_q.delete();
    end else begin
      for (int c = 0; c < NCH; c++) sz[c] = mq[c].size();
      push_w = 0;
      if (v && ch < NCH && !fl[ch]) begin
        if (sz[ch] == DEPTH) m_ovf[ch] = 1'b1;
        else push_w = 1;
      end
      load  = !m_valid || rdy;
      m_ret = '0;
      if (load) begin
        found = 0;
        sel   = 0;
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_last + k) % NCH;
          if (!found && sz[c] > 0 && !fl[c]) begin
            found = 1;
            sel   = c;
          end
        end
        if (found) begin
          m_data     = mq[sel].pop_front();
          m_chan     = CW'(sel);
          m_valid    = 1'b1;
          m_ret[sel] = 1'b1;
          m_last     = sel;
          exp_q.push_back({m_chan, m_data});
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (fl[c]) begin
          mq[c].delete();
          m_ovf[c] = 1'b0;
        end
      end
      if (push_w) mq[ch].push_back(d);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 0, '0, '0, rdy);
  endtask

  initial begin
    logic v, rdy, rst;
    int ch;
    logic [NCH-1:0] fl;

    // reset state
    step(1'b0, 0, '0, '0, 1'b0, 1'b1);
    check("rst_credit2", credit_of(2), 16);

    // single write to ch2, two-edge latency, one credit pulse
    step(1'b1, 2, 32'hA5A5A5A5, '0, 1'b1);
    check("t1_credit2_after_e", credit_of(2), 15);
    check("t1_valid_after_e", te_valid, 0);
    idle(1'b1);
    check("t1_valid", te_valid, 1);
    check("t1_chan", te_chan, 2);
    check("t1_data", te_data_out, 32'hA5A5A5A5);
    check("t1_ret", re_credit_ret, 4'b0100);
    check("t1_credit2_back", credit_of(2), 16);
    idle(1'b1);
    check("t1_ret_once", re_credit_ret, 0);

    // fill ch0 across the address wrap, overflow, ordered read-back
    for (int i = 0; i < 5; i++) step(1'b1, 0, 32'(i), '0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    for (int i = 0; i < 17; i++) step(1'b1, 0, 32'(100 + i), '0, 1'b0);
    check("t2_credit0_full", credit_of(0), 0);
    check("t2_ovf_clear", overflow[0], 0);
    step(1'b1, 0, 32'hDEAD_BEEF, '0, 1'b0);
    check("t2_ovf_set", overflow[0], 1);
    check("t2_head", te_data_out, 100);
    for (int i = 1; i <= 16; i++) begin
      idle(1'b1);
      check("t2_order", te_data_out, 32'(100 + i));
    end
    idle(1'b1);
    check("t2_drained", te_valid, 0);

    // fairness: 3 words in each of 4 channels
    step(1'b0, 0, '0, '0, 1'b0, 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCH; c++) step(1'b1, c, 32'(r * 16 + c), '0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      check("t3_rr_chan", te_chan, 32'(i % NCH));
      check("t3_rr_valid", te_valid, 1);
      idle(1'b1);
    end
    check("t3_end_valid", te_valid, 0);

    // back-pressure hold for 5 cycles
    step(1'b1, 3, 32'h3333_0001, '0, 1'b0);
    step(1'b1, 3, 32'h3333_0002, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      check("t4_hold_data", te_data_out, 32'h3333_0001);
      check("t4_hold_ret", re_credit_ret, 0);
    end
    idle(1'b1);
    check("t4_next_data", te_data_out, 32'h3333_0002);

    // flush with a simultaneous write; stage word still delivered
    step(1'b0, 0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 1, 32'(200 + i), '0, 1'b0);
    check("t5_ovf_set", overflow[1], 1);
    step(1'b1, 1, 32'h999, 4'b0010, 1'b0);
    check("t5_credit1", credit_of(1), 16);
    check("t5_ovf_cleared", overflow[1], 0);
    check("t5_stage_kept", te_data_out, 200);
    idle(1'b1);
    check("t5_no_more", te_valid, 0);
    idle(1'b1);
    check("t5_still_empty", te_valid, 0);

    // reset with channels half full
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < NCH; c++) step(1'b1, c, 32'(i), '0, 1'b0);
    step(1'b1, 2, 32'h77, '0, 1'b1, 1'b1);
    check("t6_valid", te_valid, 0);
    check("t6_credit3", credit_of(3), 16);
    check("t6_ovf", overflow, 0);
    check("t6_ret", re_credit_ret, 0);
    step(1'b1, 0, 32'h55, '0, 1'b1);
    idle(1'b1);
    check("t6_first_chan", te_chan, 0);
    check("t6_first_valid", te_valid, 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      ch = ($urandom_range(0, 1) == 0) ? (i / 400) % NCH : int'($urandom_range(0, NCH - 1));
      fl = '0;
      for (int c = 0; c < NCH; c++) fl[c] = ($urandom_range(0, 63) == 0);
      rdy = ($urandom_range(0, 9) < (((i / 500) % 2 == 1) ? 3 : 8));
      rst = ($urandom_range(0, 999) == 0);
      step(v, ch, $urandom, fl, rdy, rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
